divider_param: RTL
==================

DIVIDER_PARAM -- requirements
Module: divider_param

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand/result width in bits; legal values are even integers from 8 to 128.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  abort any operation in flight.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  divider can accept a request.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-008 SHALL have port a  input  WIDTH  dividend.
REQ-009 SHALL have port b  input  WIDTH  divisor.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port quot  output  WIDTH  quotient.
REQ-013 SHALL have port rem  output  WIDTH  remainder.
REQ-014 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, CALC and DONE; in_ready = (state==IDLE) && !flush; busy = (state!=IDLE); out_valid = (state==DONE).
REQ-016 SHALL accept a request on edge E when in_valid && in_ready; at E it SHALL latch is_signed, sign(a), sign(b), |a|, |b| and b==0, and SHALL load an iteration counter with WIDTH.
REQ-017 SHALL perform one restoring radix-2 step per CALC cycle: shift {R,Q} left by 1; if R >= |b| then subtract |b| from R and set Q[0]=1; the counter decrements by 1 per step.
REQ-018 SHALL leave CALC on the edge that completes step WIDTH, so out_valid first asserts WIDTH cycles after edge E.
REQ-019 SHALL use magnitudes only when is_signed=1; quot SHALL be negated when sign(a)^sign(b); rem SHALL be negated when sign(a) is set. Negation SHALL be WIDTH-bit two's complement with wrap-around.
REQ-020 SHALL give quot = all ones and rem = a for b==0, in both modes and regardless of the iteration result.
REQ-021 SHALL give quot = a and rem = 0 for signed overflow (a = -2^(WIDTH-1), b = -1, is_signed=1).
REQ-022 SHALL hold DONE, quot and rem stable until out_valid && out_ready; on that edge the state SHALL go to IDLE.
REQ-023 SHALL accept no new request in the same cycle as a result handoff; back-to-back operations are separated by at least one IDLE cycle.
REQ-024 SHALL, when flush=1, go to IDLE on the next edge from any state, discard the result, and not accept a request in that cycle; flush has priority over every other event.
REQ-025 SHALL ignore a, b and is_signed changes after acceptance.

Reset
REQ-026 SHALL, when resetn=0 at an edge, set state=IDLE, counter=0 and internal R/Q registers=0; the outputs after that edge SHALL be in_ready=1, out_valid=0, busy=0, quot=0, rem=0.
REQ-027 SHALL, on reset during CALC or DONE, abandon the operation with no result and no out_valid pulse.
REQ-028 SHALL give reset priority over flush and over handshakes.

Configuration
REQ-029 SHALL compile the early-exit path in only when DIVIDER_EARLY_EXIT_EN is defined.
REQ-030 SHALL, with DIVIDER_EARLY_EXIT_EN defined, go directly from IDLE to DONE at the accepting edge when b==0 or |a| < |b|; results per REQ-019/REQ-020 (quot=0 and rem=a for |a|<|b|, b!=0), with out_valid asserted 1 cycle after acceptance.
REQ-031 SHALL, without DIVIDER_EARLY_EXIT_EN, use WIDTH CALC cycles for every request, identical results.

Verification
REQ-032 SHALL cover: WIDTH=64, unsigned, a=100, b=7 -> quot=14, rem=2, out_valid exactly 64 cycles after acceptance.
REQ-033 SHALL cover: signed, a=-7, b=2 -> quot=-3 (0xFFFF_FFFF_FFFF_FFFD), rem=-1; a=7, b=-2 -> quot=-3, rem=1.
REQ-034 SHALL cover: b=0, a=0x1234, both modes -> quot=all ones, rem=0x1234; with DIVIDER_EARLY_EXIT_EN the latency is 1 cycle, otherwise 64.
REQ-035 SHALL cover: signed a=0x8000_0000_0000_0000, b=-1 -> quot=0x8000_0000_0000_0000, rem=0.
REQ-036 SHALL cover: out_ready held low 10 cycles in DONE -> quot/rem stable and in_ready=0; then flush at CALC step 30 of the next operation -> IDLE next edge, no out_valid.
REQ-037 SHALL cover: resetn=0 mid-CALC -> all outputs at reset values next cycle; WIDTH=32 run of a=0xFFFF_FFFF, b=0x10 -> quot=0x0FFF_FFFF, rem=0xF, latency 32.

Source files
------------

// File: rtl/divider_param.sv
// ============================================================================
// Module   : divider_param
// Purpose  : Iterative restoring radix-2 divider, signed/unsigned, one step
//            per cycle. Optional early exit when DIVIDER_EARLY_EXIT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module divider_param #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_shift;
  logic             r_ge;
  logic [WIDTH-1:0] r_step, q_step;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Shifted remainder needs one extra bit: it may exceed WIDTH bits before the compare.
  assign r_shift = {r_q, q_q[WIDTH-1]};
  assign r_ge    = r_shift >= {1'b0, dvs_q};
  assign r_step  = r_ge ? (r_shift[WIDTH-1:0] - dvs_q) : r_shift[WIDTH-1:0];
  assign q_step  = {q_q[WIDTH-2:0], r_ge};

  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    bz_d    = bz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            bz_d    = (b == '0);
            dvs_d   = b_mag;
            r_d     = '0;
            q_d     = a_mag;
            cnt_d   = ITERS;
            state_d = S_CALC;
`ifdef DIVIDER_EARLY_EXIT_EN
            if ((b == '0) || (a_mag < b_mag)) begin
              quot_d  = (b == '0) ? '1 : '0;
              rem_d   = a;
              cnt_d   = '0;
              state_d = S_DONE;
            end
`endif
          end
        end
        S_CALC: begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Divide-by-zero leaves |a| in R, so the sign fix-up restores rem = a.
            quot_d  = bz_q ? '1 : (negq_q ? -q_step : q_step);
            rem_d   = negr_q ? -r_step : r_step;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      bz_q    <= bz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

endmodule

`default_nettype wire
